// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

    localparam int unsigned PC_SEL_W    = 2;
    localparam int unsigned MULT_CYC    = 5;
    localparam int unsigned DIV_CYC     = 10;
    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [PC_SEL_W-1:0] PCSEL_NORM = 2'b00;
    localparam logic [PC_SEL_W-1:0] PCSEL_EXC  = 2'b01;
    localparam logic [PC_SEL_W-1:0] PCSEL_EPC  = 2'b10;

    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_timer.sv
// Mult/div busy countdown: loads on a valid issue, decrements to zero.
module pipe_stall_ctrl_md_busy_timer #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // A new issue always reloads, even if still counting (restart semantics).
    always_comb begin
        cnt_nxt = cnt;
        if (go) begin
            cnt_nxt = div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: arbitrates load-use / mult-div stalls against
// exception and eret flushes, and counts stall cycles.
module pipe_stall_ctrl #(
    parameter int unsigned MULT_CYC = pipe_stall_ctrl_pkg::MULT_CYC,
    parameter int unsigned DIV_CYC  = pipe_stall_ctrl_pkg::DIV_CYC,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_use,
    input  logic        md_useD,
    input  logic        md_startE,
    input  logic        md_divE,
    input  logic        exc_reqM,
    input  logic        eretM,
    output logic        en_pc,
    output logic        en_fd,
    output logic        clr_fd,
    output logic        clr_de,
    output logic        clr_em,
    output logic [1:0]  pc_sel,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    import pipe_stall_ctrl_pkg::*;

    logic md_go;
    logic stall;
    logic stall_sel;

    // An exception at M kills the E-stage mult/div before it can start.
    assign md_go = md_startE & ~exc_reqM;

    pipe_stall_ctrl_md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_timer (
        .clk   (clk),
        .reset (reset),
        .go    (md_go),
        .div   (md_divE),
        .busy  (md_busy)
    );

    assign stall     = load_use | (md_useD & (md_busy | md_startE));
    assign stall_sel = stall & ~exc_reqM & ~eretM;

    // Priority: exception > eret > stall > run.
    always_comb begin
        en_pc  = 1'b1;
        en_fd  = 1'b1;
        clr_fd = 1'b0;
        clr_de = 1'b0;
        clr_em = 1'b0;
        pc_sel = PCSEL_NORM;
        if (exc_reqM) begin
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
            pc_sel = PCSEL_EXC;
        end else if (eretM) begin
            clr_fd = 1'b1;
            clr_de = 1'b1;
            pc_sel = PCSEL_EPC;
        end else if (stall) begin
            en_pc  = 1'b0;
            en_fd  = 1'b0;
            clr_de = 1'b1;
        end
    end

    // Flush cycles are not stalls; counter saturates at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_sel && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Drives the enable/clear controls of the F/D, D/E and E/M pipeline registers and the PC enable/select.
- Arbitrates among three sources: load-use stalls, multi-cycle mult/div busy stalls, and exception/eret flushes.
- Owns the mult/div busy countdown and a stall-cycle performance counter.

Parameters:
- MULT_CYC, 5, cycles mult/multu keeps the MD unit busy after start.
- DIV_CYC, 10, cycles div/divu keeps the MD unit busy after start.
- CNT_W, 4, width of the busy countdown; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- load_use  in  1  decode-stage load-use hazard (combinational from hazard detect)
- md_useD  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo
- md_startE  in  1  mult/div issuing in E this cycle
- md_divE  in  1  qualifies md_startE: 1 = div/divu, 0 = mult/multu
- exc_reqM  in  1  exception/interrupt taken at M (from CP0)
- eretM  in  1  eret in M
- en_pc  out  1  PC register enable
- en_fd  out  1  F/D register EN
- clr_fd  out  1  F/D register CLR
- clr_de  out  1  D/E register CLR (bubble insert)
- clr_em  out  1  E/M register CLR
- pc_sel  out  2  PC source: 00 = normal, 01 = handler 0x0000_4180, 10 = EPC
- md_busy  out  1  MD unit busy (to E for forwarding/HI-LO guard)
- stall_cnt  out  32  total stall cycles since reset, saturating

Behaviour:
- State: countdown md_cnt[CNT_W-1:0], 32-bit stall_cnt. Both clear to 0 asynchronously on reset.
- md_busy = (md_cnt != 0). It is registered-state only; it does not include md_startE.
- Valid issue: md_go = md_startE & ~exc_reqM. An exception kills the E-stage mult/div, so it never starts.
- Countdown update each posedge clk, in priority order:
  - md_go: md_cnt <= (md_divE ? DIV_CYC : MULT_CYC).
  - else if md_busy: md_cnt <= md_cnt - 1.
  - else: hold at 0.
- md_startE while md_busy cannot legally occur; if it does, it reloads (restart semantics).
- A mult/div already counting when exc_reqM arrives keeps counting to 0 (precise HI/LO behaviour).
- Stall term: stall = load_use | (md_useD & (md_busy | md_startE)).
- Outputs are combinational from state and inputs, with priority exc_reqM > eretM > stall > run:
  - exc_reqM: en_pc=1, en_fd=1, clr_fd=1, clr_de=1, clr_em=1, pc_sel=01.
  - eretM (and no exc_reqM): en_pc=1, en_fd=1, clr_fd=1, clr_de=1, clr_em=0, pc_sel=10.
  - stall (and no exc_reqM/eretM): en_pc=0, en_fd=0, clr_fd=0, clr_de=1, clr_em=0, pc_sel=00.
  - run: en_pc=1, en_fd=1, all clears 0, pc_sel=00.
- Simultaneous events: a flush overrides a stall; the stalled D instruction is discarded by clr_fd.
- stall_cnt increments on every cycle in which the stall case is selected (a flush cycle does not count). It saturates at 0xFFFF_FFFF.
- Reset values with inputs idle: en_pc=1, en_fd=1, clr_*=0, pc_sel=00, md_busy=0, stall_cnt=0.
- Reset asserted mid-countdown: md_cnt=0 immediately, with no clock required.
- Latency: a stall or flush affects the pipeline registers at the same clock edge as the request (0-cycle). md_busy rises one cycle after md_go.

Decomposition:
- Shared package/header constants: PCSEL_NORM=2'b00, PCSEL_EXC=2'b01, PCSEL_EPC=2'b10, EXC_HANDLER=32'h0000_4180, MULT_CYC, DIV_CYC.
- One natural sub-module: md_busy_timer, holding the countdown, load and md_busy generation.
- Output priority logic and the stall counter stay in the top module.

Test Plan:
- Reset then idle: reset pulse mid-cycle → all outputs at reset values asynchronously; stall_cnt=0.
- Load-use: load_use=1 for 1 cycle → en_pc=0, en_fd=0, clr_de=1 that cycle; stall_cnt=1; run values restored next cycle.
- Mult then mflo: md_startE=1, md_divE=0 at cycle 0 with md_useD=1 held → stall cycles 0..5 (md_busy high cycles 1..5); en_fd=1 at cycle 6; stall_cnt=6.
- Div then mfhi: md_divE=1 → md_busy high exactly 10 cycles; dependent instruction stalls 11 cycles total.
- Exception during stall: md_busy=1, md_useD=1, exc_reqM=1 → clr_fd=clr_de=clr_em=1, pc_sel=01, en_pc=1; md_cnt keeps decrementing; stall_cnt unchanged.
- Exception kills issue: md_startE=1 with exc_reqM=1 → md_busy stays 0 next cycle. Separately, eretM=1 with load_use=1 → pc_sel=10, clr_fd=1, clr_em=0, no stall counted.
